// File: rtl/board_if.sv
// Command, tray-generator, debug-load and status bundle of the block-puzzle board engine.
// The bench drives the master side; board_engine sits on the slave side.
interface board_if #(
    parameter int GRID_N    = 8,
    parameter int PIECE_N   = 4,
    parameter int NUM_SLOTS = 3,
    parameter int SCORE_W   = 16
);
    logic                                   cmd_valid;
    logic [2:0]                             cmd_op;
    logic [1:0]                             cmd_slot;
    logic                                   cmd_ready;
    logic                                   cmd_err;
    logic                                   gen_req;
    logic                                   gen_valid;
    logic [NUM_SLOTS*PIECE_N*PIECE_N-1:0]   gen_pieces;
    logic                                   dbg_load;
    logic [GRID_N*GRID_N-1:0]               dbg_grid;
    logic [GRID_N*GRID_N-1:0]               grid;
    logic [NUM_SLOTS*PIECE_N*PIECE_N-1:0]   slots;
    logic [NUM_SLOTS*4-1:0]                 slot_x;
    logic [NUM_SLOTS*4-1:0]                 slot_y;
    logic [SCORE_W-1:0]                     score;
    logic [3:0]                             combo;
    logic                                   game_over;

    modport master (
        output cmd_valid, cmd_op, cmd_slot, gen_valid, gen_pieces, dbg_load, dbg_grid,
        input  cmd_ready, cmd_err, gen_req, grid, slots, slot_x, slot_y, score, combo, game_over
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_slot, gen_valid, gen_pieces, dbg_load, dbg_grid,
        output cmd_ready, cmd_err, gen_req, grid, slots, slot_x, slot_y, score, combo, game_over
    );
endinterface

// File: rtl/board_engine.sv
// Block-puzzle board engine: moves/rotates/places tray pieces, clears full rows and columns,
// scores with combo bonus, refills the tray and searches for any legal placement.
module board_engine #(
    parameter int GRID_N    = 8,
    parameter int PIECE_N   = 4,
    parameter int NUM_SLOTS = 3,
    parameter int SCORE_W   = 16
) (
    input  logic    clk,
    input  logic    reset,
    board_if.slave  bus
);
    localparam int PP    = PIECE_N * PIECE_N;
    localparam int GG    = GRID_N * GRID_N;
    localparam int SW    = NUM_SLOTS * PP;
    localparam int CW    = $clog2(PP + 1);
    localparam int SUM_W = SCORE_W + 17;
    localparam logic [3:0] XY_LAST = 4'(GRID_N - 1);

    localparam logic [2:0] OP_LEFT   = 3'd0;
    localparam logic [2:0] OP_RIGHT  = 3'd1;
    localparam logic [2:0] OP_UP     = 3'd2;
    localparam logic [2:0] OP_DOWN   = 3'd3;
    localparam logic [2:0] OP_ROTATE = 3'd4;
    localparam logic [2:0] OP_PLACE  = 3'd5;

    typedef enum logic [2:0] {IDLE, CLEAR, REFILL, CHECK, OVER} state_t;

    state_t                 state_q, state_d;
    logic [GG-1:0]          grid_q, grid_d;
    logic [SW-1:0]          slots_q, slots_d;
    logic [NUM_SLOTS*4-1:0] slot_x_q, slot_x_d, slot_y_q, slot_y_d;
    logic [SCORE_W-1:0]     score_q, score_d;
    logic [3:0]             combo_q, combo_d;
    logic                   game_over_q, game_over_d;
    logic                   cmd_err_q, cmd_err_d;
    logic                   cmd_ready_q, cmd_ready_d;
    logic                   gen_req_q, gen_req_d;
    logic [CW-1:0]          pcnt_q, pcnt_d;
    logic [1:0]             chk_slot_q, chk_slot_d;
    logic [3:0]             chk_x_q, chk_x_d, chk_y_q, chk_y_d;

    function automatic logic [CW-1:0] popcount(input logic [PP-1:0] p);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < PP; i++) n = n + CW'(p[i]);
        return n;
    endfunction

    // Origin must be on the board and every set piece bit must land on a board cell.
    function automatic logic fits(input logic [PP-1:0] p, input int x, input int y);
        logic ok;
        ok = (x >= 0) && (x < GRID_N) && (y >= 0) && (y < GRID_N);
        for (int r = 0; r < PIECE_N; r++)
            for (int c = 0; c < PIECE_N; c++)
                ok = ok && !(p[r*PIECE_N+c] && (((x + c) >= GRID_N) || ((y + r) >= GRID_N)));
        return ok;
    endfunction

    function automatic logic [GG-1:0] footprint(input logic [PP-1:0] p, input int x, input int y);
        logic [GG-1:0] m;
        m = '0;
        for (int r = 0; r < PIECE_N; r++)
            for (int c = 0; c < PIECE_N; c++)
                if (((y + r) < GRID_N) && ((x + c) < GRID_N)) m[(y+r)*GRID_N + x + c] = p[r*PIECE_N+c];
                else m = m;
        return m;
    endfunction

    function automatic logic [PP-1:0] rotate(input logic [PP-1:0] p);
        logic [PP-1:0] q;
        q = '0;
        for (int r = 0; r < PIECE_N; r++)
            for (int c = 0; c < PIECE_N; c++)
                q[c*PIECE_N + (PIECE_N-1-r)] = p[r*PIECE_N+c];
        return q;
    endfunction

    // Mask of every cell lying in a full row or full column of g.
    function automatic logic [GG-1:0] full_mask(input logic [GG-1:0] g);
        logic [GG-1:0] m;
        logic rf, cf;
        m = '0;
        for (int i = 0; i < GRID_N; i++) begin
            rf = 1'b1;
            cf = 1'b1;
            for (int j = 0; j < GRID_N; j++) begin
                rf = rf & g[i*GRID_N+j];
                cf = cf & g[j*GRID_N+i];
            end
            for (int j = 0; j < GRID_N; j++) begin
                m[i*GRID_N+j] = m[i*GRID_N+j] | rf;
                m[j*GRID_N+i] = m[j*GRID_N+i] | cf;
            end
        end
        return m;
    endfunction

    function automatic logic [5:0] full_count(input logic [GG-1:0] g);
        logic [5:0] n;
        logic rf, cf;
        n = '0;
        for (int i = 0; i < GRID_N; i++) begin
            rf = 1'b1;
            cf = 1'b1;
            for (int j = 0; j < GRID_N; j++) begin
                rf = rf & g[i*GRID_N+j];
                cf = cf & g[j*GRID_N+i];
            end
            n = n + 6'(rf) + 6'(cf);
        end
        return n;
    endfunction

    logic               slot_ok, is_move, move_ok, place_ok, chk_fit;
    int                 sel, cur_x, cur_y, nx, ny;
    logic [PP-1:0]      cur_piece, new_piece, chk_piece;
    logic [GG-1:0]      place_fp, chk_fp, clr_mask;
    logic [5:0]         lines;
    logic [3:0]         new_combo;
    logic [15:0]        bonus;
    logic [SUM_W-1:0]   score_sum;

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d     = state_q;
        grid_d      = grid_q;
        slots_d     = slots_q;
        slot_x_d    = slot_x_q;
        slot_y_d    = slot_y_q;
        score_d     = score_q;
        combo_d     = combo_q;
        pcnt_d      = pcnt_q;
        cmd_err_d   = 1'b0;
        chk_slot_d  = 2'd0;
        chk_x_d     = 4'd0;
        chk_y_d     = 4'd0;

        slot_ok   = int'(bus.cmd_slot) < NUM_SLOTS;
        sel       = slot_ok ? int'(bus.cmd_slot) : 0;
        cur_piece = slots_q[sel*PP +: PP];
        cur_x     = int'(slot_x_q[sel*4 +: 4]);
        cur_y     = int'(slot_y_q[sel*4 +: 4]);
        nx        = cur_x;
        ny        = cur_y;
        new_piece = cur_piece;
        is_move   = 1'b1;
        case (bus.cmd_op)
            OP_LEFT:   nx = cur_x - 1;
            OP_RIGHT:  nx = cur_x + 1;
            OP_UP:     ny = cur_y - 1;
            OP_DOWN:   ny = cur_y + 1;
            OP_ROTATE: new_piece = rotate(cur_piece);
            default:   is_move = 1'b0;
        endcase
        move_ok  = fits(new_piece, nx, ny);
        place_fp = footprint(cur_piece, cur_x, cur_y);
        place_ok = (cur_piece != '0) && fits(cur_piece, cur_x, cur_y) && ((place_fp & grid_q) == '0);

        clr_mask  = full_mask(grid_q);
        lines     = full_count(grid_q);
        new_combo = (lines != 6'd0) ? ((combo_q == 4'd15) ? 4'd15 : combo_q + 4'd1) : 4'd0;
        bonus     = 16'd10 * 16'(lines) * 16'(new_combo);
        score_sum = SUM_W'(score_q) + SUM_W'(pcnt_q) + SUM_W'(bonus);

        chk_piece = slots_q[int'(chk_slot_q)*PP +: PP];
        chk_fp    = footprint(chk_piece, int'(chk_x_q), int'(chk_y_q));
        chk_fit   = (chk_piece != '0) && fits(chk_piece, int'(chk_x_q), int'(chk_y_q))
                    && ((chk_fp & grid_q) == '0);

        case (state_q)
            IDLE: begin
                if (bus.dbg_load) begin
                    grid_d  = bus.dbg_grid;
                    state_d = CHECK;
                end else if (bus.cmd_valid) begin
                    if (!slot_ok) begin
                        cmd_err_d = 1'b1;
                    end else if (is_move) begin
                        if (move_ok) begin
                            slots_d[sel*PP +: PP]  = new_piece;
                            slot_x_d[sel*4 +: 4]   = 4'(nx);
                            slot_y_d[sel*4 +: 4]   = 4'(ny);
                        end else begin
                            cmd_err_d = 1'b1;
                        end
                    end else if (bus.cmd_op == OP_PLACE) begin
                        if (place_ok) begin
                            grid_d                = grid_q | place_fp;
                            slots_d[sel*PP +: PP] = '0;
                            pcnt_d                = popcount(cur_piece);
                            state_d               = CLEAR;
                        end else begin
                            cmd_err_d = 1'b1;
                        end
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CLEAR: begin
                // Rows and columns come from the same pre-clear grid, so crossings count twice.
                grid_d  = grid_q & ~clr_mask;
                combo_d = new_combo;
                if (|score_sum[SUM_W-1:SCORE_W]) score_d = '1;
                else score_d = score_sum[SCORE_W-1:0];
                state_d = (slots_q == '0) ? REFILL : CHECK;
            end
            REFILL: begin
                if (bus.gen_valid && (bus.gen_pieces != '0)) begin
                    slots_d  = bus.gen_pieces;
                    slot_x_d = '0;
                    slot_y_d = '0;
                    state_d  = CHECK;
                end else begin
                    state_d = REFILL;
                end
            end
            CHECK: begin
                chk_slot_d = chk_slot_q;
                chk_x_d    = chk_x_q;
                chk_y_d    = chk_y_q;
                if (chk_fit) begin
                    state_d = IDLE;
                end else if ((chk_piece == '0) || ((chk_x_q == XY_LAST) && (chk_y_q == XY_LAST))) begin
                    if (int'(chk_slot_q) == NUM_SLOTS - 1) begin
                        state_d = OVER;
                    end else begin
                        chk_slot_d = chk_slot_q + 2'd1;
                        chk_x_d    = 4'd0;
                        chk_y_d    = 4'd0;
                    end
                end else if (chk_x_q == XY_LAST) begin
                    chk_x_d = 4'd0;
                    chk_y_d = chk_y_q + 4'd1;
                end else begin
                    chk_x_d = chk_x_q + 4'd1;
                end
            end
            OVER:    state_d = OVER;
            default: state_d = REFILL;
        endcase

        cmd_ready_d = (state_d == IDLE);
        gen_req_d   = (state_d == REFILL);
        game_over_d = game_over_q | (state_d == OVER);
    end

    // State register with synchronous reset into REFILL on an empty board.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= REFILL;
            grid_q      <= '0;
            slots_q     <= '0;
            slot_x_q    <= '0;
            slot_y_q    <= '0;
            score_q     <= '0;
            combo_q     <= 4'd0;
            game_over_q <= 1'b0;
            cmd_err_q   <= 1'b0;
            cmd_ready_q <= 1'b0;
            gen_req_q   <= 1'b1;
            pcnt_q      <= '0;
            chk_slot_q  <= 2'd0;
            chk_x_q     <= 4'd0;
            chk_y_q     <= 4'd0;
        end else begin
            state_q     <= state_d;
            grid_q      <= grid_d;
            slots_q     <= slots_d;
            slot_x_q    <= slot_x_d;
            slot_y_q    <= slot_y_d;
            score_q     <= score_d;
            combo_q     <= combo_d;
            game_over_q <= game_over_d;
            cmd_err_q   <= cmd_err_d;
            cmd_ready_q <= cmd_ready_d;
            gen_req_q   <= gen_req_d;
            pcnt_q      <= pcnt_d;
            chk_slot_q  <= chk_slot_d;
            chk_x_q     <= chk_x_d;
            chk_y_q     <= chk_y_d;
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.cmd_err   = cmd_err_q;
    assign bus.gen_req   = gen_req_q;
    assign bus.grid      = grid_q;
    assign bus.slots     = slots_q;
    assign bus.slot_x    = slot_x_q;
    assign bus.slot_y    = slot_y_q;
    assign bus.score     = score_q;
    assign bus.combo     = combo_q;
    assign bus.game_over = game_over_q;
endmodule

// File: tb/tb_board_engine.sv
// Directed bench for board_engine at default parameters: tray refill, moves, placement,
// line clears with combo scoring, debug load, reset mid-clear and game-over search.
module tb_board_engine;
    localparam logic [2:0] OP_LEFT   = 3'd0;
    localparam logic [2:0] OP_RIGHT  = 3'd1;
    localparam logic [2:0] OP_DOWN   = 3'd3;
    localparam logic [2:0] OP_ROTATE = 3'd4;
    localparam logic [2:0] OP_PLACE  = 3'd5;

    logic clk = 1'b0;
    logic reset;
    int   n_pass  = 0;
    int   n_total = 0;
    int   n_cyc;

    board_if bif();

    board_engine dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic do_cmd(input logic [2:0] op, input logic [1:0] slot);
        bif.cmd_valid = 1'b1;
        bif.cmd_op    = op;
        bif.cmd_slot  = slot;
        tick();
        bif.cmd_valid = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (bif.cmd_ready !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        chk(tag, 64'(bif.cmd_ready), 64'd1);
    endtask

    task automatic deliver(input logic [47:0] tray);
        bif.gen_valid  = 1'b1;
        bif.gen_pieces = tray;
        tick();
        bif.gen_valid  = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        bif.cmd_valid  = 1'b0;
        bif.cmd_op     = 3'd0;
        bif.cmd_slot   = 2'd0;
        bif.gen_valid  = 1'b0;
        bif.gen_pieces = 48'd0;
        bif.dbg_load   = 1'b0;
        bif.dbg_grid   = 64'd0;
        tick();
        tick();
        chk("rst_grid",    bif.grid, 64'd0);
        chk("rst_slots",   64'(bif.slots), 64'd0);
        chk("rst_score",   64'(bif.score), 64'd0);
        chk("rst_combo",   64'(bif.combo), 64'd0);
        chk("rst_over",    64'(bif.game_over), 64'd0);
        chk("rst_err",     64'(bif.cmd_err), 64'd0);
        chk("rst_genreq",  64'(bif.gen_req), 64'd1);
        chk("rst_ready",   64'(bif.cmd_ready), 64'd0);
        reset = 1'b0;

        // All-zero delivery is refused, then the real tray loads.
        deliver(48'd0);
        chk("zero_genreq", 64'(bif.gen_req), 64'd1);
        chk("zero_slots",  64'(bif.slots), 64'd0);
        deliver(48'h0003_000F_000F);
        chk("tray_slots",  64'(bif.slots), 64'h0003_000F_000F);
        chk("tray_genreq", 64'(bif.gen_req), 64'd0);
        wait_ready("ready_a");

        do_cmd(OP_PLACE, 2'd0);
        chk("place0_grid",  bif.grid, 64'h0F);
        chk("place0_slots", 64'(bif.slots), 64'h0003_000F_0000);
        tick();
        chk("place0_score", 64'(bif.score), 64'd4);
        chk("place0_combo", 64'(bif.combo), 64'd0);
        wait_ready("ready_b");
        repeat (4) do_cmd(OP_RIGHT, 2'd1);
        chk("right4_x",   64'(bif.slot_x[7:4]), 64'd4);
        chk("right4_err", 64'(bif.cmd_err), 64'd0);
        do_cmd(OP_RIGHT, 2'd1);
        chk("right5_err", 64'(bif.cmd_err), 64'd1);
        chk("right5_x",   64'(bif.slot_x[7:4]), 64'd4);
        tick();
        chk("err_pulse",  64'(bif.cmd_err), 64'd0);
        do_cmd(OP_PLACE, 2'd1);
        chk("place1_grid", bif.grid, 64'hFF);
        tick();
        chk("clr_row_grid", bif.grid, 64'd0);
        chk("clr_row_score", 64'(bif.score), 64'd18);
        chk("clr_row_combo", 64'(bif.combo), 64'd1);
        wait_ready("ready_c");

        do_cmd(3'd6, 2'd0);
        chk("rsv_op_err", 64'(bif.cmd_err), 64'd1);
        do_cmd(OP_RIGHT, 2'd3);
        chk("bad_slot_err", 64'(bif.cmd_err), 64'd1);
        do_cmd(OP_ROTATE, 2'd2);
        chk("rot_err",   64'(bif.cmd_err), 64'd0);
        chk("rot_piece", 64'(bif.slots[47:32]), 64'h0088);
        do_cmd(OP_LEFT, 2'd2);
        chk("left_edge_err", 64'(bif.cmd_err), 64'd1);
        do_cmd(OP_PLACE, 2'd0);
        chk("place_empty_err",  64'(bif.cmd_err), 64'd1);
        chk("place_empty_grid", bif.grid, 64'd0);

        // Row 7 and column 0 both completed by one cell at (x=0, y=7).
        reset = 1'b1;
        tick();
        reset = 1'b0;
        deliver(48'h0001_0001_0001);
        wait_ready("ready_d");
        bif.dbg_load  = 1'b1;
        bif.dbg_grid  = 64'hFE01_0101_0101_0101;
        bif.cmd_valid = 1'b1;
        bif.cmd_op    = OP_PLACE;
        bif.cmd_slot  = 2'd0;
        tick();
        bif.dbg_load  = 1'b0;
        bif.cmd_valid = 1'b0;
        chk("dbg_grid",  bif.grid, 64'hFE01_0101_0101_0101);
        chk("dbg_err",   64'(bif.cmd_err), 64'd0);
        chk("dbg_slots", 64'(bif.slots), 64'h0001_0001_0001);
        wait_ready("ready_e");
        repeat (7) do_cmd(OP_DOWN, 2'd0);
        chk("down7_y", 64'(bif.slot_y[3:0]), 64'd7);
        do_cmd(OP_DOWN, 2'd0);
        chk("down8_err", 64'(bif.cmd_err), 64'd1);
        chk("down8_y",   64'(bif.slot_y[3:0]), 64'd7);
        do_cmd(OP_PLACE, 2'd0);
        chk("cross_pre",   bif.grid, 64'hFF01_0101_0101_0101);
        tick();
        chk("cross_grid",  bif.grid, 64'd0);
        chk("cross_score", 64'(bif.score), 64'd21);
        chk("cross_combo", 64'(bif.combo), 64'd1);

        // Reset during the CLEAR cycle wins over the score update.
        wait_ready("ready_f");
        do_cmd(OP_PLACE, 2'd1);
        chk("midclr_grid", bif.grid, 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midclr_score",  64'(bif.score), 64'd0);
        chk("midclr_grid0",  bif.grid, 64'd0);
        chk("midclr_combo",  64'(bif.combo), 64'd0);
        chk("midclr_slots",  64'(bif.slots), 64'd0);
        chk("midclr_y",      64'(bif.slot_y), 64'd0);
        chk("midclr_err",    64'(bif.cmd_err), 64'd0);
        chk("midclr_genreq", 64'(bif.gen_req), 64'd1);

        // Checkerboard leaves no room for a domino anywhere.
        deliver(48'h0003_0003_0003);
        wait_ready("ready_g");
        bif.dbg_load = 1'b1;
        bif.dbg_grid = 64'hAA55_AA55_AA55_AA55;
        tick();
        bif.dbg_load = 1'b0;
        n_cyc = 0;
        while (bif.game_over !== 1'b1 && n_cyc < 300) begin
            tick();
            n_cyc++;
        end
        chk("over_flag",  64'(bif.game_over), 64'd1);
        chk("over_bound", 64'(n_cyc <= 192), 64'd1);
        chk("over_ready", 64'(bif.cmd_ready), 64'd0);
        bif.cmd_valid  = 1'b1;
        bif.cmd_op     = OP_PLACE;
        bif.cmd_slot   = 2'd0;
        bif.gen_valid  = 1'b1;
        bif.gen_pieces = 48'h0001_0001_0001;
        bif.dbg_load   = 1'b1;
        bif.dbg_grid   = 64'd0;
        tick();
        tick();
        chk("over_grid",   bif.grid, 64'hAA55_AA55_AA55_AA55);
        chk("over_sticky", 64'(bif.game_over), 64'd1);
        chk("over_err",    64'(bif.cmd_err), 64'd0);
        chk("over_slots",  64'(bif.slots), 64'h0003_0003_0003);
        chk("over_genreq", 64'(bif.gen_req), 64'd0);
        bif.cmd_valid = 1'b0;
        bif.gen_valid = 1'b0;
        bif.dbg_load  = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
